// File: rtl/motor_controller.sv
// motor_controller: TB6612-style H-bridge pin driver for one timed steering motor and two drive motors
//
// Ports
//   clk, rst_n                    system clock (100 MHz), asynchronous active-low reset
//   steer_stby/dir/duty/time      steering enable, direction, PWM duty, pulse length in TICK_DIV units
//   steer_trigger                 one-cycle strobe starting (or restarting) a steering pulse
//   drive_stby                    drive driver enable
//   drive_dir_a/b, drive_duty_a/b drive motor directions and PWM duties
//   S_*                           steering driver pins (registered)
//   D_*                           drive driver pins (registered)
module motor_controller #(
    parameter int PWM_BITS  = 8,
    parameter int TICK_DIV  = 128,
    parameter int TIME_BITS = 21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 steer_stby,
    input  logic [1:0]           steer_dir,
    input  logic [PWM_BITS-1:0]  steer_duty,
    input  logic [TIME_BITS-1:0] steer_time,
    input  logic                 steer_trigger,
    input  logic                 drive_stby,
    input  logic [1:0]           drive_dir_a,
    input  logic [PWM_BITS-1:0]  drive_duty_a,
    input  logic [PWM_BITS-1:0]  drive_duty_b,
    input  logic [1:0]           drive_dir_b,
    output logic                 S_STBY,
    output logic                 S_PWMA,
    output logic                 S_AIN1,
    output logic                 S_AIN2,
    output logic                 D_STBY,
    output logic                 D_PWMA,
    output logic                 D_AIN1,
    output logic                 D_AIN2,
    output logic                 D_PWMB,
    output logic                 D_BIN1,
    output logic                 D_BIN2
);
    // Prescaler needs at least one bit even when TICK_DIV is 1.
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t               state, state_nx;
    logic [PWM_BITS-1:0]  cnt, duty_l;
    logic [1:0]           dir_l;
    logic [TIME_BITS-1:0] remain;
    logic [PW-1:0]        presc;
    logic                 load, wrap, s_on;
    always_comb begin
        load     = steer_trigger && steer_time != '0;
        wrap     = presc == PW'(TICK_DIV - 1);
        s_on     = state == ACTIVE && steer_stby;
        // A valid trigger wins over the terminal tick so a retrigger always extends the pulse.
        state_nx = load ? ACTIVE
                 : (state == ACTIVE && wrap && remain == TIME_BITS'(1)) ? IDLE
                 : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            duty_l <= '0;
            dir_l  <= '0;
            remain <= '0;
            presc  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (load) begin
                remain <= steer_time;
                presc  <= '0;
                dir_l  <= steer_dir;
                duty_l <= steer_duty;
            end else if (state == ACTIVE) begin
                presc <= wrap ? '0 : presc + 1'b1;
                if (wrap) remain <= remain - 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {S_STBY, S_PWMA, S_AIN1, S_AIN2}                         <= '0;
            {D_STBY, D_PWMA, D_AIN1, D_AIN2, D_PWMB, D_BIN1, D_BIN2} <= '0;
        end else begin
            S_STBY <= steer_stby;
            S_PWMA <= s_on && cnt < duty_l;
            S_AIN1 <= s_on && dir_l[1];
            S_AIN2 <= s_on && dir_l[0];
            D_STBY <= drive_stby;
            D_PWMA <= drive_stby && cnt < drive_duty_a;
            D_AIN1 <= drive_stby && drive_dir_a[1];
            D_AIN2 <= drive_stby && drive_dir_a[0];
            D_PWMB <= drive_stby && cnt < drive_duty_b;
            D_BIN1 <= drive_stby && drive_dir_b[1];
            D_BIN2 <= drive_stby && drive_dir_b[0];
        end
    end
endmodule

// File: tb/tb_motor_controller.sv
// tb_motor_controller: scoreboard-driven bench for motor_controller with a 1-cycle steering tick
module tb_motor_controller;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        steer_stby = 0, steer_trigger = 0, drive_stby = 0;
    logic [1:0]  steer_dir = 0, drive_dir_a = 0, drive_dir_b = 0;
    logic [7:0]  steer_duty = 0, drive_duty_a = 0, drive_duty_b = 0;
    logic [20:0] steer_time = 0;
    logic        S_STBY, S_PWMA, S_AIN1, S_AIN2;
    logic        D_STBY, D_PWMA, D_AIN1, D_AIN2, D_PWMB, D_BIN1, D_BIN2;
    logic [10:0] pins;
    int          checks = 0, failures = 0;
    int          exp_q[$];

    always #5 clk = ~clk;

    motor_controller #(.PWM_BITS(8), .TICK_DIV(1), .TIME_BITS(21)) dut (
        .clk(clk), .rst_n(rst_n),
        .steer_stby(steer_stby), .steer_dir(steer_dir), .steer_duty(steer_duty),
        .steer_time(steer_time), .steer_trigger(steer_trigger),
        .drive_stby(drive_stby), .drive_dir_a(drive_dir_a), .drive_duty_a(drive_duty_a),
        .drive_duty_b(drive_duty_b), .drive_dir_b(drive_dir_b),
        .S_STBY(S_STBY), .S_PWMA(S_PWMA), .S_AIN1(S_AIN1), .S_AIN2(S_AIN2),
        .D_STBY(D_STBY), .D_PWMA(D_PWMA), .D_AIN1(D_AIN1), .D_AIN2(D_AIN2),
        .D_PWMB(D_PWMB), .D_BIN1(D_BIN1), .D_BIN2(D_BIN2)
    );

    // Bit map: 10 S_STBY, 9 S_PWMA, 8 S_AIN1, 7 S_AIN2, 6 D_STBY, 5 D_PWMA, 4 D_AIN1, 3 D_AIN2, 2 D_PWMB, 1 D_BIN1, 0 D_BIN2
    assign pins = {S_STBY, S_PWMA, S_AIN1, S_AIN2, D_STBY, D_PWMA, D_AIN1, D_AIN2, D_PWMB, D_BIN1, D_BIN2};

    task automatic count_high(input int idx, output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            n += int'(pins[idx]);
        end
    endtask

    task automatic measure_len(input int idx, output int n);
        int w = 0;
        n = 0;
        while (pins[idx] !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        while (pins[idx] === 1'b1 && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse(input logic [1:0] d, input logic [7:0] du, input int t);
        @(negedge clk);
        steer_dir = d;
        steer_duty = du;
        steer_time = 21'(t);
        steer_trigger = 1;
        @(negedge clk);
        steer_trigger = 0;
    endtask

    task automatic test_reset;
        int e, bad;
        exp_q.push_back(0);
        #100;
        e = exp_q.pop_front();
        checks++;
        if (pins !== 11'(e)) begin
            failures++;
            $display("FAIL reset_hold: pins=%b expected=%b", pins, 11'(e));
        end
        @(negedge clk);
        rst_n = 1;
        exp_q.push_back(0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (pins !== 11'd0) bad++;
        end
        e = exp_q.pop_front();
        checks++;
        if (bad !== e) begin
            failures++;
            $display("FAIL reset_release_idle: nonzero_cycles=%0d expected=%0d", bad, e);
        end
    endtask

    task automatic test_drive;
        int e, n;
        @(negedge clk);
        drive_stby = 1;
        drive_dir_a = 2'b10;
        drive_duty_a = 100;
        drive_dir_b = 2'b01;
        drive_duty_b = 150;
        exp_q.push_back(32'b1_0_10_0_01);
        exp_q.push_back(100);
        exp_q.push_back(150);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({pins[6], 1'b0, pins[4:3], 1'b0, pins[1:0]} !== 7'(e)) begin
            failures++;
            $display("FAIL drive_dir_pins: pins=%b expected=%b", pins[6:0], 7'(e));
        end
        count_high(5, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            failures++;
            $display("FAIL drive_pwm_a: high=%0d expected=%0d", n, e);
        end
        count_high(2, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            failures++;
            $display("FAIL drive_pwm_b: high=%0d expected=%0d", n, e);
        end
        drive_stby = 0;
        exp_q.push_back(0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (pins[6:0] !== 7'(e)) begin
            failures++;
            $display("FAIL drive_standby_off: pins=%b expected=%b", pins[6:0], 7'(e));
        end
    endtask

    task automatic test_duty_extremes;
        int e, n;
        @(negedge clk);
        drive_stby = 1;
        drive_dir_a = 2'b10;
        drive_dir_b = 2'b10;
        drive_duty_a = 0;
        drive_duty_b = 255;
        exp_q.push_back(0);
        exp_q.push_back(255);
        repeat (2) @(negedge clk);
        count_high(5, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            failures++;
            $display("FAIL duty_zero: high=%0d expected=%0d", n, e);
        end
        count_high(2, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            failures++;
            $display("FAIL duty_full: high=%0d expected=%0d", n, e);
        end
        @(negedge clk);
        drive_stby = 0;
        drive_duty_a = 0;
        drive_duty_b = 0;
        drive_dir_a = 0;
        drive_dir_b = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_steer_pulse;
        int e, n;
        steer_stby = 1;
        pulse(2'b01, 128, 100);
        exp_q.push_back(100);
        exp_q.push_back(32'b101);
        measure_len(7, n);
        e = exp_q.pop_front();
        checks++;
        if (n < e - 1 || n > e + 1) begin
            failures++;
            $display("FAIL steer_length: cycles=%0d expected=%0d+-1", n, e);
        end
        e = exp_q.pop_front();
        checks++;
        if ({pins[10], pins[8:7]} !== 3'b100) begin
            failures++;
            $display("FAIL steer_end_idle: stby_in1_in2=%b expected=%b", {pins[10], pins[8:7]}, 3'b100);
        end
        // Long pulse: 50% PWM and latched values must survive input changes without a trigger.
        pulse(2'b01, 128, 1000);
        exp_q.push_back(32'b101);
        exp_q.push_back(128);
        repeat (2) @(negedge clk);
        steer_dir = 2'b10;
        steer_duty = 10;
        e = exp_q.pop_front();
        checks++;
        if ({pins[10], pins[8:7]} !== 3'(e)) begin
            failures++;
            $display("FAIL steer_active_pins: stby_in1_in2=%b expected=%b", {pins[10], pins[8:7]}, 3'(e));
        end
        count_high(9, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            failures++;
            $display("FAIL steer_pwm_50: high=%0d expected=%0d", n, e);
        end
        exp_q.push_back(32'b01);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (pins[8:7] !== 2'(e)) begin
            failures++;
            $display("FAIL steer_latched_dir: in1_in2=%b expected=%b", pins[8:7], 2'(e));
        end
        repeat (800) @(negedge clk);
    endtask

    task automatic test_retrigger;
        int e, n;
        pulse(2'b01, 128, 100);
        exp_q.push_back(32'b01);
        exp_q.push_back(50);
        repeat (30) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (pins[8:7] !== 2'(e)) begin
            failures++;
            $display("FAIL retrigger_first_dir: in1_in2=%b expected=%b", pins[8:7], 2'(e));
        end
        pulse(2'b10, 200, 50);
        measure_len(8, n);
        e = exp_q.pop_front();
        checks++;
        if (n < e - 1 || n > e + 1) begin
            failures++;
            $display("FAIL retrigger_length: cycles=%0d expected=%0d+-1", n, e);
        end
        exp_q.push_back(0);
        repeat (100) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (pins[9:7] !== 3'(e)) begin
            failures++;
            $display("FAIL retrigger_end: pwm_in1_in2=%b expected=%b", pins[9:7], 3'(e));
        end
    endtask

    task automatic test_zero_time;
        int e, bad;
        pulse(2'b11, 128, 0);
        exp_q.push_back(0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (pins[9:7] !== 3'b000) bad++;
        end
        e = exp_q.pop_front();
        checks++;
        if (bad !== e) begin
            failures++;
            $display("FAIL zero_time_ignored: active_cycles=%0d expected=%0d", bad, e);
        end
    endtask

    task automatic test_steer_stby;
        int e;
        pulse(2'b11, 255, 200);
        exp_q.push_back(0);
        exp_q.push_back(32'b111);
        exp_q.push_back(32'b100);
        repeat (10) @(negedge clk);
        steer_stby = 0;
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (pins[10:7] !== 4'(e)) begin
            failures++;
            $display("FAIL steer_stby_off: stby_pwm_in1_in2=%b expected=%b", pins[10:7], 4'(e));
        end
        repeat (98) @(negedge clk);
        steer_stby = 1;
        repeat (3) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({pins[10], pins[8:7]} !== 3'(e)) begin
            failures++;
            $display("FAIL steer_stby_resume: stby_in1_in2=%b expected=%b", {pins[10], pins[8:7]}, 3'(e));
        end
        // Timer kept running while disabled, so the pulse ends near 200 cycles after the trigger.
        repeat (97) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({pins[10], pins[8:7]} !== 3'(e)) begin
            failures++;
            $display("FAIL steer_stby_timer_runs: stby_in1_in2=%b expected=%b", {pins[10], pins[8:7]}, 3'(e));
        end
    endtask

    task automatic test_reset_mid_pulse;
        int e, bad;
        pulse(2'b10, 200, 1000);
        exp_q.push_back(0);
        exp_q.push_back(0);
        repeat (20) @(negedge clk);
        #2 rst_n = 0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (pins !== 11'(e)) begin
            failures++;
            $display("FAIL reset_mid_pulse: pins=%b expected=%b", pins, 11'(e));
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (pins[9:7] !== 3'b000) bad++;
        end
        e = exp_q.pop_front();
        checks++;
        if (bad !== e) begin
            failures++;
            $display("FAIL reset_then_idle: active_cycles=%0d expected=%0d", bad, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_drive;
        test_duty_extremes;
        test_steer_pulse;
        test_retrigger;
        test_zero_time;
        test_steer_stby;
        test_reset_mid_pulse;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
